// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC generation, redirect handling and a DEPTH-entry
// in-order buffer between a 1-cycle-latency instruction memory and decode.
module fetch_queue #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_insn,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_insn,
  output logic [XLEN-1:0]            dec_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic [31:0]     mem_insn [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     credit;

  // Credit counts the in-flight response so a push can never land on a full buffer.
  assign dec_valid = !rst && (count_q != '0) && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign push      = inflight && !redirect_valid;
  assign credit    = {1'b0, count_q} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue     = !rst && !redirect_valid && (credit < (CW+1)'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = rst ? RESET_PC : fetch_pc;
  assign dec_insn  = rst ? '0 : mem_insn[rd_ptr];
  assign dec_pc    = rst ? '0 : mem_pc[rd_ptr];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_insn[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Clearing inflight drops the wrong-path response along with the buffer.
      fetch_pc <= redirect_pc & ~(XLEN'(3));
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + XLEN'(4);
      inflight    <= issue;
      inflight_pc <= fetch_pc;
      if (push) begin
        mem_insn[wr_ptr] <= imem_insn;
        mem_pc[wr_ptr]   <= inflight_pc;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based stream model plus directed
// scenarios (reset, backpressure, redirect, alignment, PC wrap, mid-run reset).
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_0000;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

  logic        clk, rst, redirect_valid, dec_ready;
  logic [31:0] redirect_pc, imem_insn, imem_insn2;
  logic        imem_req, dec_valid, w_req, w_valid;
  logic [31:0] imem_addr, dec_insn, dec_pc, w_addr, w_insn, w_pc;
  logic [2:0]  count, w_count;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_insn(imem_insn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_insn(dec_insn), .dec_pc(dec_pc), .count(count));

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(WPC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_insn(imem_insn2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_valid(w_valid),
    .dec_ready(dec_ready), .dec_insn(w_insn), .dec_pc(w_pc), .count(w_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory emulation state (what the DUTs requested last cycle)
  logic        mreq = 1'b0, wreq = 1'b0;
  logic [31:0] maddr = '0, waddr = '0;

  // Reference model: buffered PCs in delivery order, one pending fetch, next fetch PC
  logic [31:0] m_q[$];
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;
  logic [31:0] m_fpc = RPC;

  logic        e_valid, e_req, e_pop, cur_rst;
  logic [31:0] e_addr, e_pc, e_insn;
  int          e_count;

  // One clock: drive inputs, let logic settle, compute expectations, advance the model.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    int qs;
    @(posedge clk); #1;
    imem_insn  = mreq ? (maddr ^ K) : $urandom;
    imem_insn2 = wreq ? (waddr ^ K) : $urandom;
    rst = r; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
    #3;
    mreq = imem_req; maddr = imem_addr; wreq = w_req; waddr = w_addr;
    cur_rst = r;
    qs      = m_q.size();
    e_count = qs;
    e_valid = !r && qs != 0 && !rv;
    e_pc    = r ? 32'h0 : (qs != 0 ? m_q[0] : 32'h0);
    e_insn  = r ? 32'h0 : (e_pc ^ K);
    e_pop   = e_valid && rdy;
    e_req   = !r && !rv && (qs + int'(m_pend) - int'(e_pop) < DEPTH);
    e_addr  = r ? RPC : m_fpc;
    if (r) begin
      m_q.delete(); m_pend = 1'b0; m_fpc = RPC;
    end else if (rv) begin
      m_q.delete(); m_pend = 1'b0; m_fpc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_pc);
      m_pend    = e_req;
      m_pend_pc = m_fpc;
      if (e_req) m_fpc = m_fpc + 32'd4;
    end
  endtask

  task automatic test_reset();
    int first_valid = -1;
    repeat (3) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %0b exp 0", imem_req); end
      checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL rst_imem_addr got %h exp %h", imem_addr, RPC); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid got %0b exp 0", dec_valid); end
      checks++; if (dec_pc !== 32'h0 || dec_insn !== 32'h0) begin errors++; $display("FAIL rst_dec_data got %h/%h exp 0/0", dec_pc, dec_insn); end
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (dec_valid === 1'b1 && first_valid < 0) first_valid = i;
      checks++; if (dec_valid !== e_valid) begin errors++; $display("FAIL stream_valid got %0b exp %0b", dec_valid, e_valid); end
      checks++; if (imem_req !== e_req || imem_addr !== e_addr) begin errors++; $display("FAIL stream_req got %0b@%h exp %0b@%h", imem_req, imem_addr, e_req, e_addr); end
      if (e_valid) begin
        checks++; if (dec_pc !== e_pc || dec_insn !== e_insn) begin errors++; $display("FAIL stream_data got %h/%h exp %h/%h", dec_pc, dec_insn, e_pc, e_insn); end
      end
    end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL first_valid_latency got %0d exp 2", first_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (count !== 3'(e_count)) begin errors++; $display("FAIL bp_count got %0d exp %0d", count, e_count); end
      checks++; if (imem_req !== e_req || imem_addr !== e_addr) begin errors++; $display("FAIL bp_req got %0b@%h exp %0b@%h", imem_req, imem_addr, e_req, e_addr); end
    end
    checks++; if (count !== 3'd4 || imem_req !== 1'b0 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL bp_full got count %0d req %0b addr %h exp 4 0 00000010", count, imem_req, imem_addr); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (dec_valid === 1'b1) got.push_back(dec_pc);
      checks++; if (dec_valid !== e_valid || (e_valid && dec_pc !== e_pc)) begin errors++; $display("FAIL bp_drain got %0b/%h exp %0b/%h", dec_valid, dec_pc, e_valid, e_pc); end
    end
    checks++;
    if (got.size() < 5) begin errors++; $display("FAIL bp_order got %0d pops exp >=5", got.size()); end
    else if (got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8 || got[3] !== 32'hC || got[4] !== 32'h10) begin
      errors++; $display("FAIL bp_order got %h %h %h %h %h exp 0 4 8 c 10", got[0], got[1], got[2], got[3], got[4]); end
  endtask

  task automatic test_redirect();
    int pops = 0;
    repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h200, 1'b0);
    checks++; if (count !== 3'd3 || dec_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL redir_cycle got count %0d valid %0b req %0b exp 3 0 0", count, dec_valid, imem_req); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (i == 0) begin
        checks++; if (count !== 3'd0 || imem_addr !== 32'h200) begin errors++; $display("FAIL redir_next got count %0d addr %h exp 0 00000200", count, imem_addr); end
      end
      if (dec_valid === 1'b1) begin
        if (pops == 0) begin
          checks++; if (dec_pc !== 32'h200) begin errors++; $display("FAIL redir_first_pc got %h exp 00000200", dec_pc); end
        end
        checks++; if (dec_pc === 32'hC) begin errors++; $display("FAIL redir_killed got %h exp not 0000000c", dec_pc); end
        pops++;
      end
      checks++; if (dec_valid !== e_valid || (e_valid && dec_insn !== e_insn)) begin errors++; $display("FAIL redir_stream got %0b/%h exp %0b/%h", dec_valid, dec_insn, e_valid, e_insn); end
    end
  endtask

  task automatic test_align();
    int pops = 0;
    cyc(1'b0, 1'b1, 32'h400, 1'b1);
    cyc(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (i == 0) begin
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL align_addr got %h exp 00000100", imem_addr); end
      end
      if (dec_valid === 1'b1 && pops++ == 0) begin
        checks++; if (dec_pc !== 32'h100) begin errors++; $display("FAIL align_pc got %h exp 00000100", dec_pc); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int pops = 0;
    repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (dec_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RPC) begin
      errors++; $display("FAIL midrst_during got valid %0b req %0b addr %h exp 0 0 %h", dec_valid, imem_req, imem_addr, RPC); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (i == 0) begin
        checks++; if (count !== 3'd0 || dec_valid !== 1'b0 || imem_addr !== RPC) begin
          errors++; $display("FAIL midrst_after got count %0d valid %0b addr %h exp 0 0 %h", count, dec_valid, imem_addr, RPC); end
      end
      if (dec_valid === 1'b1 && pops++ == 0) begin
        checks++; if (dec_pc !== RPC) begin errors++; $display("FAIL midrst_restart got %h exp %h", dec_pc, RPC); end
      end
      checks++; if (dec_valid !== e_valid || (e_valid && dec_pc !== e_pc)) begin errors++; $display("FAIL midrst_stream got %0b/%h exp %0b/%h", dec_valid, dec_pc, e_valid, e_pc); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (w_valid !== 1'b0 || w_addr !== WPC) begin errors++; $display("FAIL wrap_rst got valid %0b addr %h exp 0 %h", w_valid, w_addr, WPC); end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (w_valid === 1'b1) begin
        got.push_back(w_pc);
        checks++; if (w_insn !== (w_pc ^ K)) begin errors++; $display("FAIL wrap_insn got %h exp %h", w_insn, w_pc ^ K); end
      end
    end
    checks++;
    if (got.size() < 4) begin errors++; $display("FAIL wrap_seq got %0d pops exp >=4", got.size()); end
    else if (got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0 || got[3] !== 32'h4) begin
      errors++; $display("FAIL wrap_seq got %h %h %h %h exp fffffff8 fffffffc 0 4", got[0], got[1], got[2], got[3]); end
  endtask

  task automatic test_random();
    logic r, rv, rdy;
    logic [31:0] rpc;
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom % 60) == 0;
      rv  = ($urandom % 12) == 0;
      rpc = $urandom;
      rdy = ($urandom % 3) != 0;
      cyc(r, rv, rpc, rdy);
      checks++; if (dec_valid !== e_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", i, dec_valid, e_valid); end
      checks++; if (imem_req !== e_req || imem_addr !== e_addr) begin errors++; $display("FAIL rand_req cyc %0d got %0b@%h exp %0b@%h", i, imem_req, imem_addr, e_req, e_addr); end
      if (!cur_rst) begin
        checks++; if (count !== 3'(e_count)) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", i, count, e_count); end
      end
      if (e_valid || cur_rst) begin
        checks++; if (dec_pc !== e_pc || dec_insn !== e_insn) begin errors++; $display("FAIL rand_data cyc %0d got %h/%h exp %h/%h", i, dec_pc, dec_insn, e_pc, e_insn); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    imem_insn = '0; imem_insn2 = '0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_align();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
